mem_tester: RTL and testbench
=============================

# mem_tester

Test-sequence engine that drives both ports of the dual-port block RAM wrapper `mem` and checks its contents. On `start` it fills every word through port A with an address-derived pattern, then reads every word back through port B and compares `q_b` against the expected pattern. It reports a mismatch count and the first failing address. It sits directly around `mem`: it feeds `mem`'s address, data and control inputs and consumes `q_b`.

## Interface
- `WIDTH_SIZE`, 256, data word width; must be a multiple of 32.
- `NUM_WORDS_WIDTH`, 8, address width; RAM depth N = 2**NUM_WORDS_WIDTH.
- `clock`  in  1  single clock for all logic; same clock as `mem.clock`.
- `aclr`  in  1  asynchronous, active-high reset; also drives `mem.aclr`.
- `start`  in  1  sampled only in IDLE; a 1 there launches a test.
- `seed`  in  32  pattern seed, latched when `start` is accepted.
- `busy`  out  1  high from the WRITE state through the DRAIN state.
- `done`  out  1  one-cycle pulse at the end of a test.
- `err_flag`  out  1  sticky; set on the first mismatch of a test.
- `err_cnt`  out  NUM_WORDS_WIDTH+2  number of mismatching words.
- `first_err_addr`  out  NUM_WORDS_WIDTH  address of the first mismatch.
- `address_a`, `data_a`, `wren_a`, `rden_a`  out  to `mem` port A.
  - `rden_a` is tied to 0.
- `address_b`, `data_b`, `wren_b`, `rden_b`  out  to `mem` port B.
  - `wren_b` is tied to 0.
  - `data_b` is tied to 0.
- `q_b`  in  WIDTH_SIZE  unregistered read data from `mem` port B.

## Operation
- **Pattern.** pat(a) = `seed_l + a` (32-bit add, address zero-extended, result wraps modulo 2^32), replicated WIDTH_SIZE/32 times.
  - In the inverted pass the pattern is ~pat(a).
- **States:** IDLE → WRITE → READ → DRAIN → DONE → IDLE.
- **IDLE**
  - When `start`=1: latch `seed`, clear `err_cnt`, `err_flag` and `first_err_addr`, clear the address counter, then go to WRITE.
- **WRITE**
  - Each cycle: `wren_a`=1, `address_a`=counter, `data_a`=pat(counter).
  - The counter increments every cycle.
  - When the counter reaches N-1: write that word, wrap the counter to 0, go to READ.
- **READ**
  - Each cycle: `rden_b`=1, `address_b`=counter.
  - Register expected pat(counter), the address and a valid bit into the one-stage compare pipe.
  - When the counter reaches N-1: go to DRAIN.
- **Compare (stage 2)**
  - When the pipe's valid bit is high and `q_b` ≠ expected: increment `err_cnt`.
  - If `err_flag` was 0, also set it and load `first_err_addr` with the piped address.
- **DRAIN:** one cycle that finishes the compare of word N-1.
- **DONE:** `done`=1 for one cycle, then go to IDLE.
- **Result hold:** results hold until the next accepted `start`.
- **Idle outputs:** outside WRITE, `wren_a`=0; outside READ, `rden_b`=0. Addresses and `data_a` are 0 when idle.
- **Start outside IDLE:** `start` asserted in any other state is ignored. It is not queued.
- **Port collision:** no address is read in the same cycle it is written. Mixed-port read-during-write behaviour is therefore irrelevant.
- **`aclr` asserted mid-test:** the block returns to IDLE immediately and all outputs go to 0. No `done` pulse is produced for the aborted test.
- **`err_cnt` width:** the width covers 2N words, so the count never overflows.

## Timing
- **Reset values:** every output is 0, the state is IDLE and the compare pipe valid bit is 0.
- **Cycle numbering:** `start` is sampled at edge E0.
  - Writes occupy cycles 1..N.
  - Reads occupy cycles N+1..2N.
  - DRAIN is cycle 2N+1.
  - `done`=1 in cycle 2N+2, with `busy`=0 in that cycle.
- **Read latency:** `mem` registers the port-B address on `clock`, so the read issued in cycle t is compared against `q_b` in cycle t+1.
- **Error outputs:** `err_cnt` and `first_err_addr` update on the edge that ends the compare cycle.

## Configuration
- **Macro:** `MEM_TESTER_INV_PASS_EN`.
- **Defined:** after the first DRAIN, the block runs a second WRITE/READ/DRAIN pass using ~pat(a), then goes to DONE.
  - `done` moves to cycle 4N+3.
  - Errors from both passes accumulate in `err_cnt`.
  - A pass-select bit is added to the state register.
- **Undefined:** only a single pass runs, with the timing above.

## Structure
- **`mem_tester_pkg`**
  - State enum: IDLE, WRITE, READ, DRAIN, DONE.
  - `PAT_WORD_W` = 32.
  - Function `pat_word(seed, addr, inv)`.
- **Sub-module `mem_tester_pat_gen`:** combinational replication of `pat_word` to WIDTH_SIZE, shared by the write-data path and the expected-data path.

## Test plan
- **Clean pass:** NUM_WORDS_WIDTH=4, real `mem` connected, `seed`=32'h1000_0000, one `start` pulse → `done` at cycle 34, `err_cnt`=0, `err_flag`=0; RAM word 5 holds 32'h1000_0005 replicated.
- **Forced mismatch:** in the bench, force `q_b` bit 0 inverted on the read of address 3 → `err_cnt`=1, `err_flag`=1, `first_err_addr`=3.
- **Stuck-at-zero memory model:** → `err_cnt`=16, `first_err_addr`=0. With `MEM_TESTER_INV_PASS_EN` defined: `err_cnt`=32 and `done` at cycle 67.
- **Ignored start:** `start` held high throughout the test → exactly one test per IDLE visit; a second test begins at the cycle after DONE, with `err_cnt` cleared.
- **Abort:** `aclr` pulsed in cycle 20 → all outputs 0 the same cycle, no `done`; a new `start` then completes normally.
- **Seed wrap:** `seed`=32'hFFFF_FFFE → address 2 is written as 32'h0000_0000 replicated and reads back clean.

Source files
------------

// File: rtl/mem_tester_pkg.sv
// Shared types and helpers for the mem_tester block.
package mem_tester_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam int PAT_WORD_W = 32;

  // One 32-bit pattern word: seed plus zero-extended address, optionally inverted.
  function automatic logic [PAT_WORD_W-1:0] pat_word(input logic [PAT_WORD_W-1:0] seed,
                                                     input logic [PAT_WORD_W-1:0] addr,
                                                     input logic              inv);
    logic [PAT_WORD_W-1:0] w;
    w = seed + addr;
    return inv ? ~w : w;
  endfunction

endpackage

// File: rtl/mem_tester_pat_gen.sv
// Combinational pattern generator: replicates pat_word across the data width.
// One instance feeds both the write-data path and the expected-data path.
module mem_tester_pat_gen
  import mem_tester_pkg::*;
#(
  parameter int WIDTH_SIZE      = 256,
  parameter int NUM_WORDS_WIDTH = 8
) (
  input  logic [PAT_WORD_W-1:0]      seed,
  input  logic [NUM_WORDS_WIDTH-1:0] addr,
  input  logic                       inv,
  output logic [WIDTH_SIZE-1:0]      pat
);

  logic [PAT_WORD_W-1:0] addr_ext;
  logic [PAT_WORD_W-1:0] word;

  assign addr_ext = PAT_WORD_W'(addr);
  assign word     = pat_word(seed, addr_ext, inv);
  assign pat      = {(WIDTH_SIZE / PAT_WORD_W){word}};

endmodule

// File: rtl/mem_tester.sv
// Write/read-back test engine for the dual-port RAM wrapper `mem`.
// Optional feature: define MEM_TESTER_INV_PASS_EN to add a second pass
// using the inverted pattern before DONE.
module mem_tester
  import mem_tester_pkg::*;
#(
  parameter int WIDTH_SIZE      = 256,
  parameter int NUM_WORDS_WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       aclr,
  input  logic                       start,
  input  logic [31:0]                seed,
  output logic                       busy,
  output logic                       done,
  output logic                       err_flag,
  output logic [NUM_WORDS_WIDTH+1:0] err_cnt,
  output logic [NUM_WORDS_WIDTH-1:0] first_err_addr,
  output logic [NUM_WORDS_WIDTH-1:0] address_a,
  output logic [WIDTH_SIZE-1:0]      data_a,
  output logic                       wren_a,
  output logic                       rden_a,
  output logic [NUM_WORDS_WIDTH-1:0] address_b,
  output logic [WIDTH_SIZE-1:0]      data_b,
  output logic                       wren_b,
  output logic                       rden_b,
  input  logic [WIDTH_SIZE-1:0]      q_b
);

  localparam logic [NUM_WORDS_WIDTH-1:0] LAST = '1;

  state_t                     state, state_nxt;
  logic [NUM_WORDS_WIDTH-1:0] cnt, cnt_nxt;
  logic [31:0]                seed_l;
  logic                       load;
  logic                       inv;
  logic [WIDTH_SIZE-1:0]      pat;

  // one-stage compare pipe: expected data and address of the read in flight
  logic                       cmp_vld;
  logic [WIDTH_SIZE-1:0]      cmp_exp;
  logic [NUM_WORDS_WIDTH-1:0] cmp_addr;
  logic                       mism;

`ifdef MEM_TESTER_INV_PASS_EN
  logic pass, pass_nxt;
  assign inv = pass;
`else
  assign inv = 1'b0;
`endif

  mem_tester_pat_gen #(
    .WIDTH_SIZE      (WIDTH_SIZE),
    .NUM_WORDS_WIDTH (NUM_WORDS_WIDTH)
  ) u_pat (
    .seed (seed_l),
    .addr (cnt),
    .inv  (inv),
    .pat  (pat)
  );

  assign mism = cmp_vld && (q_b != cmp_exp);

  // next-state and sequencing
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
`ifdef MEM_TESTER_INV_PASS_EN
    pass_nxt  = pass;
`endif
    case (state)
      ST_IDLE: if (start) begin
        state_nxt = ST_WRITE;
        cnt_nxt   = '0;
        load      = 1'b1;
`ifdef MEM_TESTER_INV_PASS_EN
        pass_nxt  = 1'b0;
`endif
      end
      // counter wraps to 0 naturally on the last word
      ST_WRITE: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST) state_nxt = ST_READ;
      end
      ST_READ: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
`ifdef MEM_TESTER_INV_PASS_EN
        if (!pass) begin
          state_nxt = ST_WRITE;
          pass_nxt  = 1'b1;
        end else begin
          state_nxt = ST_DONE;
        end
`else
        state_nxt = ST_DONE;
`endif
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // RAM port drive decoded from the current state
  always_comb begin
    wren_a    = (state == ST_WRITE);
    rden_b    = (state == ST_READ);
    address_a = wren_a ? cnt : '0;
    data_a    = wren_a ? pat : '0;
    address_b = rden_b ? cnt : '0;
    busy      = (state == ST_WRITE) || (state == ST_READ) || (state == ST_DRAIN);
    done      = (state == ST_DONE);
    rden_a    = 1'b0;
    wren_b    = 1'b0;
    data_b    = '0;
  end

  // state, counter, seed, compare pipe and result registers
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      seed_l         <= '0;
      cmp_vld        <= 1'b0;
      cmp_exp        <= '0;
      cmp_addr       <= '0;
      err_cnt        <= '0;
      err_flag       <= 1'b0;
      first_err_addr <= '0;
`ifdef MEM_TESTER_INV_PASS_EN
      pass           <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      cmp_vld  <= (state == ST_READ);
      cmp_exp  <= pat;
      cmp_addr <= cnt;
`ifdef MEM_TESTER_INV_PASS_EN
      pass     <= pass_nxt;
`endif
      if (load) begin
        seed_l         <= seed;
        err_cnt        <= '0;
        err_flag       <= 1'b0;
        first_err_addr <= '0;
      end else if (mism) begin
        err_cnt <= err_cnt + 1'b1;
        if (!err_flag) begin
          err_flag       <= 1'b1;
          first_err_addr <= cmp_addr;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_tester.sv
// Self-checking bench for mem_tester with a behavioural dual-port RAM and
// injectable read faults (per-address bit-0 flip, or stuck-at-zero output).
module tb_mem_tester;

  localparam int W  = 64;
  localparam int AW = 4;
  localparam int N  = 1 << AW;
`ifdef MEM_TESTER_INV_PASS_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif
  localparam int DONE_CYC = (PASSES == 2) ? 4 * N + 3 : 2 * N + 2;

  logic          clock = 1'b0;
  logic          aclr;
  logic          start;
  logic [31:0]   seed;
  logic          busy, done, err_flag;
  logic [AW+1:0] err_cnt;
  logic [AW-1:0] first_err_addr;
  logic [AW-1:0] address_a, address_b;
  logic [W-1:0]  data_a, data_b, q_b;
  logic          wren_a, rden_a, wren_b, rden_b;

  int n_chk  = 0;
  int n_fail = 0;

  mem_tester #(.WIDTH_SIZE(W), .NUM_WORDS_WIDTH(AW)) dut (
    .clock          (clock),
    .aclr           (aclr),
    .start          (start),
    .seed           (seed),
    .busy           (busy),
    .done           (done),
    .err_flag       (err_flag),
    .err_cnt        (err_cnt),
    .first_err_addr (first_err_addr),
    .address_a      (address_a),
    .data_a         (data_a),
    .wren_a         (wren_a),
    .rden_a         (rden_a),
    .address_b      (address_b),
    .data_b         (data_b),
    .wren_b         (wren_b),
    .rden_b         (rden_b),
    .q_b            (q_b)
  );

  always #5 clock = ~clock;

  // behavioural RAM: registered port-B address, unregistered q_b
  logic [W-1:0]  ram [N];
  logic [AW-1:0] rd_addr_q;
  logic          stuck0;
  logic [N-1:0]  flip_mask;

  always @(posedge clock or posedge aclr) begin
    if (aclr) rd_addr_q <= '0;
    else begin
      if (wren_a) ram[address_a] <= data_a;
      if (rden_b) rd_addr_q <= address_b;
    end
  end

  always_comb begin
    q_b = '0;
    if (!stuck0) q_b = ram[rd_addr_q] ^ W'(flip_mask[rd_addr_q]);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_word(input logic [31:0] s, input int a, input bit inv);
    logic [31:0] w;
    w = s + 32'(a);
    if (inv) w = ~w;
    return {(W / 32){w}};
  endfunction

  // reference: what the engine should count given the fault setup
  task automatic model(input logic [31:0] s, output int cnt, output int first);
    logic [W-1:0] rd, ex;
    cnt = 0;
    first = 0;
    for (int p = 0; p < PASSES; p++)
      for (int a = 0; a < N; a++) begin
        ex = exp_word(s, a, p == 1);
        rd = stuck0 ? '0 : (ex ^ W'(flip_mask[a]));
        if (rd != ex) begin
          if (cnt == 0) first = a;
          cnt++;
        end
      end
  endtask

  // count cycles from c0 until done, bounded
  task automatic wait_done(input int c0, output int c);
    c = c0;
    while (1) begin
      @(negedge clock);
      c++;
      if (c == 1) chk("busy_c1", busy, 1);
      if (done) begin
        chk("busy_at_done", busy, 0);
        break;
      end
      if (c > 4 * DONE_CYC) begin
        chk("done_timeout", 1, 0);
        break;
      end
    end
  endtask

  task automatic run_test(input string tag, input logic [31:0] s);
    int c, ecnt, efirst;
    model(s, ecnt, efirst);
    @(negedge clock);
    seed  = s;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    wait_done(0, c);
    chk({tag, "_done_cyc"}, c, DONE_CYC);
    chk({tag, "_err_cnt"}, err_cnt, ecnt);
    chk({tag, "_err_flag"}, err_flag, ecnt != 0);
    chk({tag, "_first"}, first_err_addr, efirst);
    @(negedge clock);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_hold_cnt"}, err_cnt, ecnt);
  endtask

  initial begin
    int c, seen;
    aclr = 1'b1; start = 1'b0; seed = '0; stuck0 = 1'b0; flip_mask = '0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", {err_flag, err_cnt, first_err_addr}, 0);
    chk("rst_porta", {wren_a, rden_a, address_a, data_a}, 0);
    chk("rst_portb", {wren_b, rden_b, address_b, data_b}, 0);
    @(negedge clock);
    aclr = 1'b0;

    // clean pass
    run_test("clean", 32'h1000_0000);
`ifdef MEM_TESTER_INV_PASS_EN
    chk("ram5", ram[5], ~{2{32'h1000_0005}});
`else
    chk("ram5", ram[5], {2{32'h1000_0005}});
`endif

    // forced mismatch at address 3
    flip_mask = 16'h0008;
    run_test("flip3", 32'h1000_0000);
    chk("flip3_spec_first", first_err_addr, 3);
    flip_mask = '0;

    // stuck-at-zero memory
    stuck0 = 1'b1;
    run_test("stuck0", 32'h1000_0000);
    chk("stuck0_spec_cnt", err_cnt, 16 * PASSES);
    stuck0 = 1'b0;

    // seed wrap
    run_test("wrap", 32'hFFFF_FFFE);
`ifdef MEM_TESTER_INV_PASS_EN
    chk("wrap_ram2", ram[2], '1);
`else
    chk("wrap_ram2", ram[2], '0);
`endif

    // start held high: one test per IDLE visit, results cleared on re-launch
    flip_mask = 16'h0001;
    @(negedge clock);
    seed  = 32'h0000_1234;
    start = 1'b1;
    @(posedge clock);
    wait_done(0, c);
    chk("held_done_cyc", c, DONE_CYC);
    chk("held_err_cnt", err_cnt, PASSES);
    @(negedge clock);
    chk("held_idle_busy", busy, 0);
    chk("held_idle_hold", err_cnt, PASSES);
    @(negedge clock);
    flip_mask = '0;
    start = 1'b0;
    chk("held_relaunch_busy", busy, 1);
    chk("held_relaunch_wren", wren_a, 1);
    chk("held_relaunch_clr", err_cnt, 0);
    wait_done(1, c);
    chk("held2_done_cyc", c, DONE_CYC);
    chk("held2_err_cnt", err_cnt, 0);

    // abort in cycle 20 with errors already counted
    flip_mask = 16'h0003;
    @(negedge clock);
    seed  = 32'h0BAD_0000;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    for (int i = 1; i <= 20; i++) @(negedge clock);
    chk("abort_pre_err", err_cnt, 2);
    aclr = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_err", {err_flag, err_cnt, first_err_addr}, 0);
    chk("abort_ports", {wren_a, address_a, data_a, rden_b, address_b}, 0);
    @(negedge clock);
    aclr = 1'b0;
    seen = 0;
    for (int i = 0; i < DONE_CYC + 10; i++) begin
      @(negedge clock);
      if (done) seen++;
    end
    chk("abort_no_done", seen, 0);
    flip_mask = '0;
    run_test("after_abort", 32'h0BAD_0000);

    // randomized seeds and fault patterns
    for (int k = 0; k < 6; k++) begin
      stuck0    = ($urandom_range(0, 3) == 0);
      flip_mask = ($urandom_range(0, 2) == 0) ? '0 : N'($urandom);
      run_test($sformatf("rnd%0d", k), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

endmodule
